// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
//   - Active-low glyph constants {g,f,e,d,c,b,a} for digits 0-9, blank and dash
//   - Converter FSM state type
//   - Helpers: decimal digit -> glyph, largest value displayable on N digits
package seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_e;

    // Non-decimal nibbles cannot occur after a valid conversion; show blank.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // 10^digits - 1, evaluated at elaboration time.
    function automatic longint unsigned max_display_value(input int unsigned digits);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accept bin (only acted on while idle)
//   bin        : unsigned binary input
//   busy       : conversion in progress (not idle)
//   done       : one-cycle pulse while bcd/ovf hold the finished result
//   bcd        : BCD scratch, NUM_DIGITS nibbles, nibble 0 least significant
//   ovf        : captured value does not fit in NUM_DIGITS decimal digits
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = $clog2(DATA_W);
    localparam logic [63:0] MAX_VAL = max_display_value(NUM_DIGITS);

    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [BCD_W-1:0]  adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              over_range;
    logic              last_iter;

    assign over_range = 64'(bin) > MAX_VAL;
    assign last_iter  = cnt_q == CNT_W'(DATA_W - 1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = over_range ? CONV_COMMIT : CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (last_iter) begin
                    state_d = CONV_COMMIT;
                end
            end
            CONV_COMMIT: state_d = CONV_IDLE;
            default:     state_d = CONV_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = state_q != CONV_IDLE;
        done = state_q == CONV_COMMIT;
    end

    assign bcd = scratch_q;
    assign ovf = ovf_q;

    // One double-dabble iteration: correct nibbles >= 5, then shift in the
    // next input MSB. The top bit falls off; overflowing inputs never get here.
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d      = sr_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    sr_d      = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    ovf_d     = over_range;
                end
            end
            CONV_SHIFT: begin
                scratch_d = BCD_W'({adj, sr_q[DATA_W-1]});
                sr_d      = sr_q << 1;
                cnt_d     = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode seven-segment driver with BCD conversion.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_data valid; accepted when in_ready is high
//   in_data    : unsigned binary value to display
//   in_ready   : converter idle
//   blank_lz   : blank leading zeros (digit 0 always shown)
//   blink_mask : per-digit blink enable, bit 0 = least significant digit
//   DISPLAY    : registered active-low segments {g,f,e,d,c,b,a}
//   DIGIT      : registered active-low one-hot anode select, MSB = MSD
module seven_segment_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [6:0]            DISPLAY,
    output logic [NUM_DIGITS-1:0] DIGIT
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W  = $clog2(BLINK_DIV);
    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic             start;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf;

    assign in_ready = ~conv_busy;
    assign start    = in_valid & ~conv_busy;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (in_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Display register, loaded on the converter's commit cycle
    logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
    logic             disp_ovf_q, disp_ovf_d;

    always_comb begin
        disp_bcd_d = disp_bcd_q;
        disp_ovf_d = disp_ovf_q;
        if (conv_done) begin
            disp_bcd_d = conv_bcd;
            disp_ovf_d = conv_ovf;
        end
    end

    // Refresh divider and slot index
    logic [DIV_W-1:0]  div_q, div_d;
    logic              slot_tick;
    logic [SLOT_W-1:0] slot_q, slot_d;

    assign slot_tick = div_q == DIV_W'(SCAN_DIV - 1);

    always_comb begin
        div_d  = slot_tick ? '0 : div_q + 1'b1;
        slot_d = slot_q;
        if (slot_tick) begin
            slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
        end
    end

    // Free-running blink phase
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        blink_d   = blink_q;
        if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end
    end

    // lz_vec[i]: digit i and every more-significant digit are zero (never digit 0)
    logic [NUM_DIGITS-1:0] lz_vec;

    always_comb begin
        lz_vec = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            lz_vec[i] = 1'b1;
            for (int unsigned j = i; j < NUM_DIGITS; j++) begin
                if (disp_bcd_q[4*j +: 4] != 4'd0) begin
                    lz_vec[i] = 1'b0;
                end
            end
        end
    end

    // Slot k drives digit NUM_DIGITS-1-k (most significant first)
    logic [NUM_DIGITS-1:0] anode;
    logic [3:0]            sel_nib;
    logic                  sel_blink;
    logic                  sel_lz;
    logic [6:0]            glyph;

    always_comb begin
        anode     = '1;
        sel_nib   = '0;
        sel_blink = 1'b0;
        sel_lz    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SLOT_W'(NUM_DIGITS - 1 - i)) begin
                anode[i]  = 1'b0;
                sel_nib   = disp_bcd_q[4*i +: 4];
                sel_blink = blink_mask[i];
                sel_lz    = lz_vec[i];
            end
        end
    end

    always_comb begin
        if (disp_ovf_q) begin
            glyph = GLYPH_DASH;
        end else if (blink_q && sel_blink) begin
            glyph = GLYPH_BLANK;
        end else if (blank_lz && sel_lz) begin
            glyph = GLYPH_BLANK;
        end else begin
            glyph = digit_glyph(sel_nib);
        end
    end

    // Anode and segments load together so they never disagree for a cycle
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic [6:0]            display_q, display_d;

    always_comb begin
        digit_d   = digit_q;
        display_d = display_q;
        if (slot_tick) begin
            digit_d   = anode;
            display_d = glyph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
            div_q      <= '0;
            slot_q     <= '0;
            blk_cnt_q  <= '0;
            blink_q    <= 1'b0;
            digit_q    <= '1;
            display_q  <= GLYPH_BLANK;
        end else begin
            disp_bcd_q <= disp_bcd_d;
            disp_ovf_q <= disp_ovf_d;
            div_q      <= div_d;
            slot_q     <= slot_d;
            blk_cnt_q  <= blk_cnt_d;
            blink_q    <= blink_d;
            digit_q    <= digit_d;
            display_q  <= display_d;
        end
    end

    assign DIGIT   = digit_q;
    assign DISPLAY = display_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

    localparam int ND = 4;
    localparam int DW = 14;
    localparam int SD = 4;
    localparam int BD = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          blank_lz = 1'b0;
    logic [ND-1:0] blink_mask = '0;
    logic [6:0]    DISPLAY;
    logic [ND-1:0] DIGIT;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seven_segment_scan #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .DISPLAY    (DISPLAY),
        .DIGIT      (DIGIT)
    );

    // Reference glyphs {g,f,e,d,c,b,a}, active-low
    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p;
        p = 1;
        repeat (n) p = p * 10;
        return p;
    endfunction

    // Behavioural model: edges counted from reset release, value visibility
    // from accept edge plus latency, digits by decimal arithmetic.
    initial begin : model
        int n, e, k, di, q;
        logic busy, pend_o, disp_o;
        int commit_e, pend_v, disp_v;
        logic phase;
        logic [ND-1:0] exp_dig;
        logic [6:0] exp_seg;
        n = 0; busy = 0; disp_v = 0; disp_o = 0; pend_v = 0; pend_o = 0; commit_e = 0;
        exp_dig = '1; exp_seg = 7'b1111111;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n = 0; busy = 0; disp_v = 0; disp_o = 0;
                exp_dig = '1; exp_seg = 7'b1111111;
                chk("rst ready", in_ready, 1);
                chk("rst digit", DIGIT, exp_dig);
                chk("rst display", DISPLAY, exp_seg);
            end else begin
                e = n + 1;
                if (busy && (e - 1) >= commit_e) begin
                    disp_v = pend_v; disp_o = pend_o; busy = 0;
                end
                chk("model ready", in_ready, !busy);
                chk("model digit", DIGIT, exp_dig);
                chk("model display", DISPLAY, exp_seg);
                if (e % SD == 0) begin
                    k = (e / SD - 1) % ND;
                    di = ND - 1 - k;
                    exp_dig = '1;
                    exp_dig[di] = 1'b0;
                    phase = ((e - 1) / BD) % 2 == 1;
                    q = disp_v / pow10(di);
                    if (disp_o) exp_seg = 7'b0111111;
                    else if (phase && blink_mask[di]) exp_seg = 7'b1111111;
                    else if (blank_lz && di != 0 && q == 0) exp_seg = 7'b1111111;
                    else exp_seg = glyph_tab[q % 10];
                end
                if (!busy && in_valid) begin
                    busy = 1;
                    pend_o = int'(in_data) > pow10(ND) - 1;
                    pend_v = int'(in_data);
                    commit_e = e + (pend_o ? 1 : DW + 1);
                end
                n = e;
            end
        end
    end

    task automatic start(input int v);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        in_data = DW'(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output int lc);
        lc = 0;
        while (!in_ready && lc < 100) begin
            lc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int v, output int lc);
        start(v);
        wait_ready(lc);
    endtask

    // Check one full scan starting at the MSD slot; ex indexed by digit
    task automatic scan_expect(input string tag, input logic [ND-1:0][6:0] ex);
        int t;
        logic [ND-1:0] ed;
        repeat (ND * SD) @(posedge clk);
        #1;
        t = 0;
        while (DIGIT !== 4'b0111 && t < 64) begin
            @(posedge clk); #1; t++;
        end
        chk({tag, " sync"}, t < 64, 1);
        for (int s = 0; s < ND; s++) begin
            ed = '1;
            ed[ND-1-s] = 1'b0;
            chk({tag, " digit"}, DIGIT, ed);
            chk({tag, " seg"}, DISPLAY, ex[ND-1-s]);
            repeat (SD) @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        int lc, t;
        logic seen_g, seen_b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset DIGIT", DIGIT, 4'b1111);
        chk("reset DISPLAY", DISPLAY, 7'b1111111);
        chk("reset in_ready", in_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (SD) @(posedge clk);
        #1;
        chk("first slot DIGIT", DIGIT, 4'b0111);
        chk("first slot DISPLAY", DISPLAY, 7'b1000000);

        send(1234, lc);
        chk("1234 busy cycles", lc, 15);
        scan_expect("1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

        blank_lz = 1'b1;
        send(7, lc);
        scan_expect("lz 7", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
        send(0, lc);
        scan_expect("lz 0", {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
        blank_lz = 1'b0;

        send(10000, lc);
        chk("ovf busy cycles", lc, 1);
        scan_expect("ovf", {4{7'b0111111}});
        send(9999, lc);
        chk("9999 busy cycles", lc, 15);
        scan_expect("9999", {4{7'b0010000}});

        send(1234, lc);
        blink_mask = 4'b0001;
        seen_g = 0; seen_b = 0;
        for (int r = 0; r < 8; r++) begin
            t = 0;
            while (DIGIT !== 4'b1110 && t < 64) begin
                @(posedge clk); #1; t++;
            end
            if (DISPLAY === 7'b0011001) seen_g = 1;
            if (DISPLAY === 7'b1111111) seen_b = 1;
            repeat (SD) @(posedge clk);
            #1;
        end
        chk("blink glyph seen", seen_g, 1);
        chk("blink blank seen", seen_b, 1);
        blink_mask = '0;

        start(4321);
        @(posedge clk); #1;
        in_data = DW'(5678);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ready(lc);
        chk("ignored pulse busy tail", lc > 0 && lc < 15, 1);
        scan_expect("4321", {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001});

        start(4321);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst DIGIT", DIGIT, 4'b1111);
        chk("async rst DISPLAY", DISPLAY, 7'b1111111);
        chk("async rst in_ready", in_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (SD) @(posedge clk);
        #1;
        chk("post rst DIGIT", DIGIT, 4'b0111);
        chk("post rst DISPLAY", DISPLAY, 7'b1000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
